// File: rtl/mac_stream_pkg.sv
// mac_stream_pkg: shared width helpers, accumulator range constants and the
// wrap/saturate adder used by the accumulate stage.
package mac_stream_pkg;

  // Widest accumulator the generic adder handles (ACC_W must stay below this)
  localparam int MAX_W = 64;

  function automatic int p_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Largest unsigned value of a w-bit word
  function automatic logic [MAX_W-1:0] umax(input int w);
    return (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction

  // Largest positive two's-complement value of a w-bit word
  function automatic logic [MAX_W-1:0] smax(input int w);
    return umax(w) >> 1;
  endfunction

  // Most negative two's-complement value of a w-bit word (bit pattern)
  function automatic logic [MAX_W-1:0] smin(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

  // w-bit add returning {ovf, sum}; sum wraps, or clamps when sat is set
  function automatic logic [MAX_W:0] acc_add(input logic [MAX_W-1:0] x,
                                             input logic [MAX_W-1:0] y,
                                             input int w,
                                             input logic sgn,
                                             input logic sat);
    logic [MAX_W:0]   full;
    logic [MAX_W-1:0] msk;
    logic [MAX_W-1:0] s;
    logic             carry;
    logic             xs;
    logic             ys;
    logic             ss;
    logic             ovf;
    msk   = umax(w);
    full  = {1'b0, x & msk} + {1'b0, y & msk};
    s     = full[MAX_W-1:0] & msk;
    carry = |(full >> w);
    xs    = |(x & smin(w));
    ys    = |(y & smin(w));
    ss    = |(s & smin(w));
    ovf   = sgn ? ((xs == ys) && (ss != xs)) : carry;
    if (sat && ovf) begin
      s = sgn ? (xs ? smin(w) : smax(w)) : msk;
    end
    return {ovf, s};
  endfunction

endpackage

// File: rtl/mac_stream_if.sv
// mac_stream_if: operand stream in, packet results out. The master drives
// operands and clr; the slave (mac_stream) drives the results.
interface mac_stream_if #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic             clr;
  logic             in_valid;
  logic             in_last;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output clr, in_valid, in_last, a, b,
    input  acc_out, out_valid, out_data, out_cnt, out_ovf
  );

  modport slave (
    input  clr, in_valid, in_last, a, b,
    output acc_out, out_valid, out_data, out_cnt, out_ovf
  );
endinterface

// File: rtl/mac_stream_acc.sv
// mac_stream_acc: accumulate stage. Adds each registered product into the
// packet accumulator, counts terms, tracks overflow and captures the packet
// result on the last term. Build option MAC_SAT_EN: clamp instead of wrap.
module mac_stream_acc
  import mac_stream_pkg::*;
#(
  parameter int P_W    = 16,
  parameter int ACC_W  = 16,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             vld_p1,
  input  logic             last_p1,
  input  logic [P_W-1:0]   prod_p1,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

`ifdef MAC_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic             SGN     = (SIGNED != 0);

  logic             first_p2;
  logic [ACC_W-1:0] acc_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic             ovf_p2;

  logic [MAX_W-1:0] prod_ext;
  logic [MAX_W-1:0] base;
  logic [MAX_W:0]   add_res;
  logic [ACC_W-1:0] sum;
  logic             sum_ovf;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unused_hi;

  assign prod_ext  = {{(MAX_W-P_W){SGN & prod_p1[P_W-1]}}, prod_p1};
  assign base      = first_p2 ? '0 : {{(MAX_W-ACC_W){1'b0}}, acc_p2};
  assign add_res   = acc_add(base, prod_ext, ACC_W, SGN, SAT);
  assign sum       = add_res[ACC_W-1:0];
  assign sum_ovf   = add_res[MAX_W];
  assign unused_hi = ^add_res[MAX_W-1:ACC_W];
  assign cnt_nxt   = first_p2 ? CNT_W'(1) :
                     ((cnt_p2 == CNT_MAX) ? cnt_p2 : cnt_p2 + 1'b1);
  assign ovf_nxt   = (first_p2 ? 1'b0 : ovf_p2) | sum_ovf;
  assign acc_out   = acc_p2;

  // ---- stage A: accumulate, count, flag overflow, capture packet result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_p2  <= 1'b1;
      acc_p2    <= '0;
      cnt_p2    <= '0;
      ovf_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      first_p2  <= 1'b1;
      acc_p2    <= '0;
      cnt_p2    <= '0;
      ovf_p2    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (vld_p1) begin
        acc_p2   <= sum;
        cnt_p2   <= cnt_nxt;
        ovf_p2   <= ovf_nxt;
        first_p2 <= last_p1;
        if (last_p1) begin
          out_valid <= 1'b1;
          out_data  <= sum;
          out_cnt   <= cnt_nxt;
          out_ovf   <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/mac_stream.sv
// mac_stream: pipelined multiply-accumulate over valid/last delimited packets.
// Stage P registers a*b; stage A (mac_stream_acc) accumulates. Build option
// MAC_SAT_EN makes the accumulator saturate on overflow instead of wrapping.
module mac_stream
  import mac_stream_pkg::*;
#(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int ACC_W  = 16,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  mac_stream_if.slave  bus
);

  localparam int P_W = p_width(A_W, B_W);

  if (ACC_W < P_W) begin : g_bad_acc_w
    $error("mac_stream: ACC_W must be >= A_W+B_W");
  end
  if (ACC_W >= MAX_W) begin : g_acc_too_wide
    $error("mac_stream: ACC_W must be below mac_stream_pkg::MAX_W");
  end

  logic [P_W-1:0] prod_p0;
  logic [P_W-1:0] prod_p1;
  logic           vld_p1;
  logic           last_p1;

  if (SIGNED != 0) begin : g_mul_s
    logic signed [P_W-1:0] sprod;
    assign sprod   = P_W'($signed(bus.a)) * P_W'($signed(bus.b));
    assign prod_p0 = sprod;
  end else begin : g_mul_u
    assign prod_p0 = P_W'(bus.a) * P_W'(bus.b);
  end

  // ---- stage P: register product and packet qualifiers; clr drops input ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      prod_p1 <= '0;
    end else if (bus.clr) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= bus.in_valid;
      last_p1 <= bus.in_valid & bus.in_last;
      if (bus.in_valid) begin
        prod_p1 <= prod_p0;
      end
    end
  end

  mac_stream_acc #(
    .P_W    (P_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.clr),
    .vld_p1    (vld_p1),
    .last_p1   (last_p1),
    .prod_p1   (prod_p1),
    .acc_out   (bus.acc_out),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_cnt   (bus.out_cnt),
    .out_ovf   (bus.out_ovf)
  );

endmodule

// File: tb/tb_mac_stream.sv
// tb_mac_stream: drives an unsigned and a signed mac_stream with the same
// operand stream and checks both against an integer packet model every cycle.
module tb_mac_stream;

`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mac_stream_if #(.A_W(8), .B_W(8), .ACC_W(16), .CNT_W(8)) iu ();
  mac_stream_if #(.A_W(8), .B_W(8), .ACC_W(16), .CNT_W(8)) isg ();

  mac_stream #(.A_W(8), .B_W(8), .ACC_W(16), .SIGNED(0), .CNT_W(8)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (iu)
  );

  mac_stream #(.A_W(8), .B_W(8), .ACC_W(16), .SIGNED(1), .CNT_W(8)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (isg)
  );

  int checks = 0;
  int failures = 0;

  // Model state, index 0 = unsigned DUT, 1 = signed DUT
  bit     s1v   [2];
  bit     s1l   [2];
  longint s1p   [2];
  bit     first [2];
  longint macc  [2];
  int     mcnt  [2];
  bit     movf  [2];
  bit     ev    [2];
  longint ed    [2];
  int     ec    [2];
  bit     eo    [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bits16(input longint v);
    logic [63:0] t;
    t = v;
    return {16'h0, t[15:0]};
  endfunction

  function automatic longint product(input int d, input logic [7:0] x, input logic [7:0] y);
    if (d == 1) return longint'($signed(x)) * longint'($signed(y));
    return longint'(x) * longint'(y);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      s1v[d] = 0; s1l[d] = 0; s1p[d] = 0; first[d] = 1;
      macc[d] = 0; mcnt[d] = 0; movf[d] = 0;
      ev[d] = 0; ed[d] = 0; ec[d] = 0; eo[d] = 0;
    end
  endtask

  // One clock edge of the packet-level model
  task automatic model_edge(input int d, input logic v, input logic l, input logic c,
                            input logic [7:0] x, input logic [7:0] y);
    longint s;
    bit     o;
    if (!rst_n) begin
      s1v[d] = 0; s1l[d] = 0; s1p[d] = 0; first[d] = 1;
      macc[d] = 0; mcnt[d] = 0; movf[d] = 0;
      ev[d] = 0; ed[d] = 0; ec[d] = 0; eo[d] = 0;
    end else if (c) begin
      s1v[d] = 0; s1l[d] = 0; first[d] = 1;
      macc[d] = 0; mcnt[d] = 0; movf[d] = 0; ev[d] = 0;
    end else begin
      ev[d] = 0;
      if (s1v[d]) begin
        s = (first[d] ? 0 : macc[d]) + s1p[d];
        if (d == 0) begin
          o = (s > 65535);
          if (o) s = SAT ? 65535 : s - 65536;
        end else begin
          o = (s > 32767) || (s < -32768);
          if (o) begin
            if (SAT) s = (s > 0) ? 32767 : -32768;
            else     s = (s > 0) ? s - 65536 : s + 65536;
          end
        end
        mcnt[d] = first[d] ? 1 : ((mcnt[d] < 255) ? mcnt[d] + 1 : 255);
        movf[d] = (first[d] ? 1'b0 : movf[d]) | o;
        macc[d] = s;
        first[d] = s1l[d];
        if (s1l[d]) begin
          ev[d] = 1; ed[d] = s; ec[d] = mcnt[d]; eo[d] = movf[d];
        end
      end
      s1v[d] = v;
      s1l[d] = v & l;
      s1p[d] = product(d, x, y);
    end
  endtask

  task automatic check_dut(input int d, input string nm, input logic vld,
                           input logic [15:0] data, input logic [15:0] acc,
                           input logic [7:0] cnt, input logic ovf);
    check({nm, "_valid"}, {31'b0, vld}, {31'b0, ev[d]});
    check({nm, "_data"}, {16'b0, data}, bits16(ed[d]));
    check({nm, "_acc"}, {16'b0, acc}, bits16(macc[d]));
    check({nm, "_cnt"}, {24'b0, cnt}, ec[d]);
    check({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo[d]});
  endtask

  task automatic check_all();
    check_dut(0, "u", iu.out_valid, iu.out_data, iu.acc_out, iu.out_cnt, iu.out_ovf);
    check_dut(1, "s", isg.out_valid, isg.out_data, isg.acc_out, isg.out_cnt, isg.out_ovf);
  endtask

  task automatic cyc(input logic v, input logic l, input logic [7:0] x,
                     input logic [7:0] y, input logic c);
    iu.in_valid = v;  iu.in_last = l;  iu.a = x;  iu.b = y;  iu.clr = c;
    isg.in_valid = v; isg.in_last = l; isg.a = x; isg.b = y; isg.clr = c;
    @(posedge clk);
    model_edge(0, v, l, c, x, y);
    model_edge(1, v, l, c, x, y);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
  endtask

  initial begin
    logic       v;
    logic       l;
    logic       c;
    logic [7:0] x;
    logic [7:0] y;

    iu.in_valid = 0;  iu.in_last = 0;  iu.a = 0;  iu.b = 0;  iu.clr = 0;
    isg.in_valid = 0; isg.in_last = 0; isg.a = 0; isg.b = 0; isg.clr = 0;

    // Reset state
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_acc", {16'b0, iu.acc_out}, 32'h0);
    check("rst_valid", {31'b0, iu.out_valid}, 32'h0);
    check("rst_data", {16'b0, iu.out_data}, 32'h0);
    check("rst_cnt", {24'b0, iu.out_cnt}, 32'h0);
    check("rst_ovf", {31'b0, iu.out_ovf}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Four-term packet: 6+20+42+2 = 70
    cyc(1, 0, 8'd2, 8'd3, 0);
    cyc(1, 0, 8'd5, 8'd4, 0);
    cyc(1, 0, 8'd6, 8'd7, 0);
    cyc(1, 1, 8'd1, 8'd2, 0);
    cyc(0, 0, 8'd0, 8'd0, 0);
    check("t1_valid", {31'b0, iu.out_valid}, 32'h1);
    check("t1_data", {16'b0, iu.out_data}, 32'd70);
    check("t1_cnt", {24'b0, iu.out_cnt}, 32'd4);
    check("t1_ovf", {31'b0, iu.out_ovf}, 32'h0);
    check("t1_sdata", {16'b0, isg.out_data}, 32'd70);
    idle(1);
    check("t1_pulse", {31'b0, iu.out_valid}, 32'h0);
    check("t1_hold", {16'b0, iu.out_data}, 32'd70);

    // Back-to-back single-term packets
    cyc(1, 1, 8'd3, 8'd3, 0);
    cyc(1, 1, 8'd4, 8'd4, 0);
    check("t2_data0", {16'b0, iu.out_data}, 32'd9);
    idle(1);
    check("t2_valid1", {31'b0, iu.out_valid}, 32'h1);
    check("t2_data1", {16'b0, iu.out_data}, 32'd16);
    check("t2_cnt1", {24'b0, iu.out_cnt}, 32'd1);
    idle(1);

    // Bubbles inside a packet
    cyc(1, 0, 8'd2, 8'd2, 0);
    idle(1);
    check("t3_acc_idle", {16'b0, iu.acc_out}, 32'd4);
    idle(2);
    check("t3_acc_hold", {16'b0, iu.acc_out}, 32'd4);
    cyc(1, 1, 8'd2, 8'd2, 0);
    idle(1);
    check("t3_data", {16'b0, iu.out_data}, 32'd8);
    check("t3_cnt", {24'b0, iu.out_cnt}, 32'd2);

    // Unsigned overflow
    cyc(1, 0, 8'd255, 8'd255, 0);
    cyc(1, 1, 8'd255, 8'd255, 0);
    idle(1);
    check("t4_ovf", {31'b0, iu.out_ovf}, 32'h1);
    check("t4_data", {16'b0, iu.out_data}, SAT ? 32'hFFFF : 32'hFC02);
    check("t4_sdata", {16'b0, isg.out_data}, 32'd2);
    check("t4_sovf", {31'b0, isg.out_ovf}, 32'h0);

    // Signed: -12 + 10 = -2
    cyc(1, 0, 8'hFD, 8'd4, 0);
    cyc(1, 1, 8'd2, 8'd5, 0);
    idle(1);
    check("t5_sdata", {16'b0, isg.out_data}, 32'hFFFE);
    check("t5_sovf", {31'b0, isg.out_ovf}, 32'h0);
    check("t5_data", {16'b0, iu.out_data}, 32'd1022);

    // clr mid-packet; same-cycle input dropped, result kept
    cyc(1, 0, 8'd7, 8'd7, 0);
    cyc(1, 0, 8'd9, 8'd9, 1);
    check("t6_clr_hold", {16'b0, isg.out_data}, 32'hFFFE);
    check("t6_clr_acc", {16'b0, iu.acc_out}, 32'h0);
    cyc(1, 1, 8'd1, 8'd1, 0);
    idle(1);
    check("t6_data", {16'b0, iu.out_data}, 32'd1);
    check("t6_cnt", {24'b0, iu.out_cnt}, 32'd1);

    // Asynchronous reset mid-packet
    cyc(1, 0, 8'd5, 8'd5, 0);
    cyc(1, 0, 8'd6, 8'd6, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_acc", {16'b0, iu.acc_out}, 32'h0);
    check("t6_rst_data", {16'b0, iu.out_data}, 32'h0);
    check("t6_rst_cnt", {24'b0, iu.out_cnt}, 32'h0);
    check("t6_rst_valid", {31'b0, iu.out_valid}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Term counter saturation: 260 terms of 1*1
    for (int i = 0; i < 259; i++) cyc(1, 0, 8'd1, 8'd1, 0);
    cyc(1, 1, 8'd1, 8'd1, 0);
    idle(1);
    check("cnt_sat", {24'b0, iu.out_cnt}, 32'd255);
    check("cnt_sat_data", {16'b0, iu.out_data}, 32'd260);

    // Randomized traffic with bubbles, packet ends and occasional clr
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 31) == 0);
      x = 8'($urandom);
      y = 8'($urandom);
      cyc(v, l, x, y, c);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
